// File: rtl/rom_read_sequencer_pkg.sv
// Shared definitions for the ROM read sequencer: default widths, FSM state
// encoding and the word order of the twelve half-words on rom_q.
package rom_read_sequencer_pkg;

  localparam int RADIX_W_DEF = 6;
  localparam int D_W_DEF     = 64;
  localparam int BURST_LEN   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } seq_state_e;

  // Position of each wrapper half-word on rom_q, word 0 in the LSBs.
  typedef enum int {
    W_ROM0_B0_HA = 0,
    W_ROM0_B0_LA = 1,
    W_ROM0_B1_HA = 2,
    W_ROM0_B1_LA = 3,
    W_ROM1_B0_HA = 4,
    W_ROM1_B0_LA = 5,
    W_ROM1_B1_HA = 6,
    W_ROM1_B1_LA = 7,
    W_ROM2_B0_HA = 8,
    W_ROM2_B0_LA = 9,
    W_ROM2_B1_HA = 10,
    W_ROM2_B1_LA = 11
  } rom_word_e;

  localparam int NUM_WORDS = int'(W_ROM2_B1_LA) + 1;

endpackage

// File: rtl/rom_phase_fifo.sv
// Capture FIFO for tagged phase results; output data reads as zero while empty.
module rom_phase_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_q];

endmodule

// File: rtl/rom_read_sequencer.sv
// Issues 4-phase ROM read bursts and queues each captured phase for output.
// Build option: define ROM_SEQ_B2B_EN to accept a new request at phase 3.
module rom_read_sequencer
  import rom_read_sequencer_pkg::*;
#(
  parameter int RADIX_W    = RADIX_W_DEF,
  parameter int D_W        = D_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [RADIX_W-1:0]       req_ma0,
  input  logic [RADIX_W-1:0]       req_ma1,
  input  logic [RADIX_W-1:0]       req_ma2,
  output logic                     ROM_CEN,
  output logic [RADIX_W-1:0]       MA0,
  output logic [RADIX_W-1:0]       MA1,
  output logic [RADIX_W-1:0]       MA2,
  input  logic [NUM_WORDS*D_W-1:0] rom_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_WORDS*D_W-1:0] out_data,
  output logic [1:0]               out_phase,
  output logic                     out_last
);

  localparam int QW = NUM_WORDS * D_W;
  localparam int FW = QW + 2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = CW + 1;

  seq_state_e         state_q;
  logic [1:0]         ph_q;
  logic               cen_q;
  logic [RADIX_W-1:0] ma0_q, ma1_q, ma2_q;
  logic               run_q;
  logic               vld_q;
  logic [1:0]         tag_q;
  logic [PW-1:0]      pend_q, pend_d;

  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [FW-1:0]      fifo_rd;
  logic [PW-1:0]      free_w;
  logic               credit_ok, accept_slot, accept;

  // pend_q counts phases already committed to a burst but not yet pushed.
  assign free_w    = PW'(FIFO_DEPTH) - PW'(fifo_count);
  assign credit_ok = !fifo_full && (free_w >= pend_q + PW'(BURST_LEN));

`ifdef ROM_SEQ_B2B_EN
  assign accept_slot = (state_q == IDLE) || (ph_q == 2'd3);
`else
  assign accept_slot = (state_q == IDLE);
`endif

  assign req_ready = run_q && accept_slot && credit_ok;
  assign accept    = req_valid && req_ready;

  // Stage p0: burst control and ROM address registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      ph_q    <= 2'd0;
      cen_q   <= 1'b1;
      ma0_q   <= '0;
      ma1_q   <= '0;
      ma2_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BURST;
            ph_q    <= 2'd0;
            cen_q   <= 1'b0;
            ma0_q   <= req_ma0;
            ma1_q   <= req_ma1;
            ma2_q   <= req_ma2;
          end
        end
        BURST: begin
          if (ph_q != 2'd3) begin
            ph_q <= ph_q + 2'd1;
          end else if (accept) begin
            ph_q  <= 2'd0;
            ma0_q <= req_ma0;
            ma1_q <= req_ma1;
            ma2_q <= req_ma2;
          end else begin
            state_q <= IDLE;
            ph_q    <= 2'd0;
            cen_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cen_q   <= 1'b1;
        end
      endcase
    end
  end

  assign ROM_CEN = cen_q;
  assign MA0     = ma0_q;
  assign MA1     = ma1_q;
  assign MA2     = ma2_q;

  assign pend_d = pend_q + (accept ? PW'(BURST_LEN) : PW'(0)) - (vld_q ? PW'(1) : PW'(0));

  // Stage p1: valid/phase delay line aligning the tag with rom_q
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld_q  <= 1'b0;
      tag_q  <= 2'd0;
      pend_q <= '0;
    end else begin
      vld_q  <= (state_q == BURST);
      tag_q  <= ph_q;
      pend_q <= pend_d;
    end
  end

  // Stage p2: capture FIFO and output handshake
  rom_phase_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_n),
    .push      (vld_q),
    .push_data ({tag_q, rom_q}),
    .pop       (out_valid && out_ready),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd[QW-1:0];
  assign out_phase = fifo_rd[QW +: 2];
  assign out_last  = out_valid && (out_phase == 2'd3);

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Scoreboard bench for rom_read_sequencer: a ROM model drives fresh rom_q data
// every cycle and the monitor predicts each captured phase from ROM_CEN.
module tb_rom_read_sequencer;

  localparam int RW = 6;
  localparam int DW = 16;
  localparam int FD = 8;
  localparam int QW = 12 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [RW-1:0] req_ma0, req_ma1, req_ma2;
  logic          ROM_CEN;
  logic [RW-1:0] MA0, MA1, MA2;
  logic [QW-1:0] rom_q;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_data;
  logic [1:0]    out_phase;
  logic          out_last;

  rom_read_sequencer #(
    .RADIX_W    (RW),
    .D_W        (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ma0   (req_ma0),
    .req_ma1   (req_ma1),
    .req_ma2   (req_ma2),
    .ROM_CEN   (ROM_CEN),
    .MA0       (MA0),
    .MA1       (MA1),
    .MA2       (MA2),
    .rom_q     (rom_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_phase (out_phase),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int accepts = 0;
  int outs    = 0;

  logic [QW+1:0]   exp_q[$];
  logic [3*RW-1:0] req_q[$];
  logic [3*RW-1:0] cur_ma;
  logic [QW+1:0]   e;
  bit              prev_low;
  logic [1:0]      bph, prev_ph;
  bit              stall_prev;
  logic [QW-1:0]   prev_data;
  logic [1:0]      prev_phase;

  // ROM model: new random contents after every rising edge.
  initial begin
    rom_q = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < QW / 32; i++) rom_q[i*32 +: 32] = $urandom;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      exp_q.delete();
      req_q.delete();
      prev_low   = 1'b0;
      bph        = 2'd0;
      stall_prev = 1'b0;
    end else begin
      if (prev_low) exp_q.push_back({prev_ph, rom_q});
      if (!ROM_CEN) begin
        if (bph == 2'd0) begin
          if (req_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL burst_no_request: ROM_CEN low with no accepted request");
          end else begin
            cur_ma = req_q.pop_front();
          end
        end
        vectors++;
        if ({MA0, MA1, MA2} !== cur_ma) begin
          errors++;
          $display("FAIL ma_hold: got %h required %h (ph %0d)", {MA0, MA1, MA2}, cur_ma, bph);
        end
        prev_ph  = bph;
        bph      = bph + 2'd1;
        prev_low = 1'b1;
      end else begin
        prev_low = 1'b0;
      end
      if (req_valid && req_ready) begin
        req_q.push_back({req_ma0, req_ma1, req_ma2});
        accepts++;
      end
      if (stall_prev) begin
        vectors++;
        if (!out_valid || out_data !== prev_data || out_phase !== prev_phase) begin
          errors++;
          $display("FAIL stall_stable: got v=%b ph=%0d required v=1 ph=%0d (data held %0b)",
                   out_valid, out_phase, prev_phase, out_data === prev_data);
        end
      end
      if (out_valid && out_ready) begin
        outs++;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got phase %0d required no output", out_phase);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e[QW-1:0] || out_phase !== e[QW +: 2] ||
              out_last !== (e[QW +: 2] == 2'd3)) begin
            errors++;
            $display("FAIL out_data: got ph=%0d last=%b d=%h required ph=%0d last=%b d=%h",
                     out_phase, out_last, out_data, e[QW +: 2], e[QW +: 2] == 2'd3, e[QW-1:0]);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_phase = out_phase;
    end
  end

  task automatic wait_outs(input int target, input int budget);
    int n = 0;
    while (outs < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send_req(input logic [RW-1:0] a0, input logic [RW-1:0] a1,
                          input logic [RW-1:0] a2, output bit ok);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_ma0 = a0; req_ma1 = a1; req_ma2 = a2;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    ok = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
    req_ma0 = '0; req_ma1 = '0; req_ma2 = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ROM_CEN !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got cen=%b ov=%b rr=%b last=%b required 1 0 0 0",
               ROM_CEN, out_valid, req_ready, out_last);
    end
    vectors++;
    if (MA0 !== '0 || MA1 !== '0 || MA2 !== '0 || out_data !== '0 || out_phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: got MA=%h,%h,%h ph=%0d data nonzero=%0b required zeros",
               MA0, MA1, MA2, out_phase, out_data !== '0);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 0 before first edge", req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle: got %b required 1", req_ready);
    end
  endtask

  task automatic test_single();
    int base = outs;
    int lows = 0;
    bit ok;
    out_ready = 1'b1;
    send_req(6'd5, 6'd9, 6'd63, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL single_accept: got not accepted required accepted");
    end
    repeat (10) begin
      @(negedge clk);
      if (!ROM_CEN) lows++;
    end
    vectors++;
    if (lows != 4) begin
      errors++;
      $display("FAIL single_cen_len: got %0d required 4", lows);
    end
    wait_outs(base + 4, 40);
    vectors++;
    if (outs != base + 4) begin
      errors++;
      $display("FAIL single_outputs: got %0d required 4", outs - base);
    end
  endtask

  task automatic test_back_to_back();
    int base_a = accepts;
    int base_o = outs;
    int first = -1, last = -1, lows = 0, k = 0, gap;
    int exp_gap;
`ifdef ROM_SEQ_B2B_EN
    exp_gap = 0;
`else
    exp_gap = 1;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_ma0 = 6'd1; req_ma1 = 6'd2; req_ma2 = 6'd3;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (!ROM_CEN) begin
        if (first < 0) first = i;
        last = i;
        lows++;
      end
      if (req_valid && req_ready) k++;
      @(posedge clk); #1;
      if (k == 1) begin req_ma0 = 6'd4; req_ma1 = 6'd5; req_ma2 = 6'd6; end
      if (k >= 2) req_valid = 1'b0;
    end
    gap = (first < 0) ? -1 : (last - first + 1) - lows;
    vectors++;
    if (lows != 8 || accepts - base_a != 2) begin
      errors++;
      $display("FAIL b2b_lows: got %0d lows %0d accepts required 8 lows 2 accepts",
               lows, accepts - base_a);
    end
    vectors++;
    if (gap != exp_gap) begin
      errors++;
      $display("FAIL b2b_gap: got %0d required %0d", gap, exp_gap);
    end
    wait_outs(base_o + 8, 40);
    vectors++;
    if (outs != base_o + 8) begin
      errors++;
      $display("FAIL b2b_outputs: got %0d required 8", outs - base_o);
    end
  endtask

  task automatic test_backpressure();
    int base_a = accepts;
    int base_o = outs;
    logic [RW-1:0] m = 6'd20;
    out_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_ma0 = m; req_ma1 = m + 6'd1; req_ma2 = m + 6'd2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) m = m + 6'd3;
      @(posedge clk); #1;
      req_ma0 = m; req_ma1 = m + 6'd1; req_ma2 = m + 6'd2;
    end
    @(negedge clk);
    vectors++;
    if (accepts - base_a != 2) begin
      errors++;
      $display("FAIL bp_accepts: got %0d required 2", accepts - base_a);
    end
    vectors++;
    if (req_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got rr=%b ov=%b required rr=0 ov=1", req_ready, out_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    out_ready = 1'b1;
    wait_outs(base_o + 8, 60);
    repeat (4) @(negedge clk);
    vectors++;
    if (outs != base_o + 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d outputs %0d left required 8 outputs 0 left",
               outs - base_o, exp_q.size());
    end
  endtask

  task automatic test_toggle();
    int base_o = outs;
    int k = 0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_ma0 = 6'd40; req_ma1 = 6'd41; req_ma2 = 6'd42;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) k++;
      @(posedge clk); #1;
      out_ready = ~out_ready;
      if (k == 1) begin req_ma0 = 6'd50; req_ma1 = 6'd51; req_ma2 = 6'd52; end
      if (k >= 2) req_valid = 1'b0;
    end
    out_ready = 1'b1;
    wait_outs(base_o + 8, 40);
    repeat (2) @(negedge clk);
    vectors++;
    if (outs != base_o + 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_count: got %0d outputs %0d left required 8 outputs 0 left",
               outs - base_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base_o;
    int seen = 0;
    bit ok;
    out_ready = 1'b1;
    send_req(6'd10, 6'd20, 6'd30, ok);
    @(posedge clk);
    @(posedge clk);
    #2;
    vectors++;
    if (ROM_CEN !== 1'b0) begin
      errors++;
      $display("FAIL mid_burst_setup: got cen=%b required 0 at ph2", ROM_CEN);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ROM_CEN !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got cen=%b ov=%b required cen=1 ov=0", ROM_CEN, out_valid);
    end
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || !ROM_CEN) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_residue: got %0d active cycles required 0", seen);
    end
    base_o = outs;
    send_req(6'd33, 6'd44, 6'd55, ok);
    wait_outs(base_o + 4, 40);
    vectors++;
    if (outs != base_o + 4) begin
      errors++;
      $display("FAIL mid_fresh: got %0d outputs required 4", outs - base_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
